// File: rtl/od_gpio_bank.sv
// -----------------------------------------------------------------------------
// od_gpio_bank
//
// Bank of N independent open-drain GPIO channels. Each channel debounces an
// asynchronous button request and, once the request is accepted, pulls its
// pad low. The pad is never driven high. The pad is also monitored for
// activity from other agents on the wire: a low level that the block did not
// cause raises LED, produces a one-cycle fall_evt pulse and sets a sticky
// status flag. A pad that reads high while the block has been pulling it low
// for several cycles is reported as a fault.
//
// Parameters
//   N          number of channels (1..16)
//   DB_CYCLES  consecutive stable cycles needed to accept a button change
//              (2..65535)
//
// Ports
//   clk       rising-edge clock for all state
//   rst       asynchronous, active-high reset
//   button    per-channel drive request, asynchronous (1 = pull pad low)
//   Dinout    open-drain pads, pulled up externally
//   clr       per-channel write-1-to-clear for status
//   LED       1 = pad held low by an external agent
//   fall_evt  one-cycle pulse on an external falling edge
//   status    sticky external-falling-edge flags
//   fault     1 = pad reads high while this block drives it low
// -----------------------------------------------------------------------------
module od_gpio_bank #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button,
  inout  wire  [N-1:0] Dinout,
  input  logic [N-1:0] clr,
  output logic [N-1:0] LED,
  output logic [N-1:0] fall_evt,
  output logic [N-1:0] status,
  output logic [N-1:0] fault
);

  localparam int              CW       = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch

    // Button synchronizer and debouncer
    logic          btn_m;
    logic          btn_s;
    logic          db;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;
    logic          en;

    assign differ = (btn_s != db);
    assign accept = differ && (cnt == CNT_LAST);
    assign en     = db;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, whatever the order
    // of statements inside the block.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        btn_m <= 1'b0;
        btn_s <= 1'b0;
        cnt   <= '0;
        db    <= 1'b0;
      end else begin
        btn_m <= button[i];
        btn_s <= btn_m;
        if (accept) begin
          db  <= btn_s;
          cnt <= '0;
        end else if (differ) begin
          cnt <= cnt + CW'(1);
        end else begin
          // Synchronized input agrees with the accepted level again: any
          // partial run was a glitch and is forgotten.
          cnt <= '0;
        end
      end
    end

    // Open-drain pad: pull low or float, never drive high. Because en is a
    // flop with asynchronous reset, the pad floats as soon as rst rises.
    assign Dinout[i] = en ? 1'b0 : 1'bz;

    // Pad synchronizer, blanking and age of the current drive
    logic       pad_m;
    logic       pad_s;
    logic [1:0] blank_cnt;
    logic [1:0] en_age;
    logic       blank;
    logic       din_eff;

    // Blanking covers our own drive plus two cycles after release, which is
    // how long the synchronizer keeps showing the low we caused ourselves.
    assign blank   = en || (blank_cnt != 2'd0);
    assign din_eff = blank ? 1'b1 : pad_s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: the pad synchronizer resets to the pulled-up idle level rather
        // than 0; a 0 here would look like an external low for the first two
        // cycles after reset and raise LED and fall_evt on every release.
        pad_m     <= 1'b1;
        pad_s     <= 1'b1;
        blank_cnt <= 2'd0;
        en_age    <= 2'd0;
      end else begin
        pad_m <= Dinout[i];
        pad_s <= pad_m;

        // Load at the same edge that db drops, so blank never has a gap.
        if (accept && db) begin
          blank_cnt <= 2'd2;
        end else if (blank_cnt != 2'd0) begin
          blank_cnt <= blank_cnt - 2'd1;
        end

        // en_age saturates at 2: with en high now, that means en has been
        // high for at least three consecutive cycles, long enough for our
        // own low to have travelled through the pad synchronizer.
        if (!en) begin
          en_age <= 2'd0;
        end else if (en_age != 2'd2) begin
          en_age <= en_age + 2'd1;
        end
      end
    end

    // External activity detection and reporting
    logic din_q;
    logic fall_cond;
    logic led_r;
    logic fall_r;
    logic status_r;
    logic fault_r;

    assign fall_cond = din_q && !din_eff;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // din_q starts high so reset release is never seen as a falling edge.
        din_q    <= 1'b1;
        led_r    <= 1'b0;
        fall_r   <= 1'b0;
        status_r <= 1'b0;
        fault_r  <= 1'b0;
      end else begin
        din_q    <= din_eff;
        led_r    <= !din_eff;
        fall_r   <= fall_cond;
        // A new event beats a simultaneous clear so no edge is ever lost.
        status_r <= fall_cond || (status_r && !clr[i]);
        fault_r  <= en && (en_age == 2'd2) && pad_s;
      end
    end

    assign LED[i]      = led_r;
    assign fall_evt[i] = fall_r;
    assign status[i]   = status_r;
    assign fault[i]    = fault_r;

  end : g_ch

endmodule : od_gpio_bank

// File: tb/tb_od_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_od_gpio_bank
//
// Self-checking bench for od_gpio_bank (N=4, DB_CYCLES=16). The pads are
// modelled as a pulled-up wire that the bench can also pull low (ext_low) or
// overpower high (force_hi). A behavioural reference model tracks every
// channel cycle by cycle from the block's stated rules; directed scenario
// tasks check fixed latencies, and a randomized run compares every output
// and pad against the model.
// -----------------------------------------------------------------------------
module tb_od_gpio_bank;

  localparam int N  = 4;
  localparam int DB = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] button   = '0;
  logic [N-1:0] clr      = '0;
  logic [N-1:0] ext_low  = '0;
  logic [N-1:0] force_hi = '0;
  wire  [N-1:0] pad;
  logic [N-1:0] LED;
  logic [N-1:0] fall_evt;
  logic [N-1:0] status;
  logic [N-1:0] fault;

  int n_vec = 0;
  int n_err = 0;

  od_gpio_bank #(.N(N), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .Dinout   (pad),
    .clr      (clr),
    .LED      (LED),
    .fall_evt (fall_evt),
    .status   (status),
    .fault    (fault)
  );

  for (genvar g = 0; g < N; g++) begin : g_pad
    pullup pu (pad[g]);
    assign pad[g] = force_hi[g] ? 1'b1 : (ext_low[g] ? 1'b0 : 1'bz);
  end

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [N-1:0] m_b1, m_bs, m_db, m_p1, m_ps, m_dq;
  bit [N-1:0] m_led, m_fall, m_stat, m_fault;
  int         m_run    [N];  // consecutive samples disagreeing with accepted level
  int         m_blank  [N];  // blank cycles left after a release
  int         m_en_run [N];  // consecutive cycles the channel has been driving

  // Pad level the wire should show given the accepted drive and the agents.
  function automatic logic [N-1:0] pads_exp();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++)
      p[i] = force_hi[i] ? 1'b1 : ((m_db[i] || ext_low[i]) ? 1'b0 : 1'b1);
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b1 = '0; m_bs = '0; m_db = '0;
      m_p1 = '1; m_ps = '1; m_dq = '1;
      m_led = '0; m_fall = '0; m_stat = '0; m_fault = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_blank[i] = 0; m_en_run[i] = 0;
      end
    end else begin
      logic [N-1:0] pnow;
      pnow = pads_exp();
      for (int i = 0; i < N; i++) begin
        bit blank, eff, fell;
        blank = m_db[i] || (m_blank[i] > 0);
        eff   = blank ? 1'b1 : m_ps[i];
        fell  = m_dq[i] && !eff;
        m_fault[i] = m_db[i] && (m_en_run[i] >= 3) && m_ps[i];
        m_led[i]   = !eff;
        m_fall[i]  = fell;
        m_stat[i]  = fell || (m_stat[i] && !clr[i]);
        m_dq[i]    = eff;
        if (m_blank[i] > 0) m_blank[i]--;
        if (m_bs[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            if (m_db[i]) m_blank[i] = 2;
            m_db[i]  = m_bs[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_en_run[i] = m_db[i] ? m_en_run[i] + 1 : 0;
        m_bs[i] = m_b1[i];
        m_b1[i] = button[i];
        m_ps[i] = m_p1[i];
        m_p1[i] = pnow[i];
      end
    end
  end

  // One clock: pass a rising edge, stop on the following falling edge where
  // outputs are sampled and new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    n_vec++;
    if ({LED, fall_evt, status, fault} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0", {LED, fall_evt, status, fault});
    end
    n_vec++;
    if (pad !== '1) begin
      n_err++;
      $display("FAIL reset_pads got=%b want=1111", pad);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_vec++;
      if ((LED | fall_evt | status) !== '0) begin
        n_err++;
        $display("FAIL reset_release k=%0d LED=%b fall=%b status=%b want=0", k, LED, fall_evt, status);
      end
    end
  endtask

  // Accepted press drives the pad low on the (DB+2)th edge with no report.
  task automatic test_drive();
    button[0] = 1'b1;
    for (int k = 1; k <= DB + 4; k++) begin
      logic want;
      cyc();
      want = (k >= DB + 2) ? 1'b0 : 1'b1;
      n_vec++;
      if (pad[0] !== want) begin
        n_err++;
        $display("FAIL drive_pad0 edge=%0d got=%b want=%b", k, pad[0], want);
      end
      n_vec++;
      if ({LED[0], fall_evt[0], status[0]} !== 3'b000) begin
        n_err++;
        $display("FAIL drive_quiet0 edge=%0d LED/fall/status=%b want=000", k, {LED[0], fall_evt[0], status[0]});
      end
    end
  endtask

  // Channel 0 is driving; overpower the pad high and then let go.
  task automatic test_fault();
    idle(4);
    n_vec++;
    if (fault[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fault_idle got=%b want=0", fault[0]);
    end
    force_hi[0] = 1'b1;
    clr         = '1;
    for (int k = 1; k <= 5; k++) begin
      logic want;
      cyc();
      want = (k >= 3);
      n_vec++;
      if (fault[0] !== want) begin
        n_err++;
        $display("FAIL fault_set edge=%0d got=%b want=%b", k, fault[0], want);
      end
    end
    force_hi[0] = 1'b0;
    clr         = '0;
    for (int k = 1; k <= 4; k++) begin
      logic want;
      cyc();
      want = (k < 3);
      n_vec++;
      if (fault[0] !== want) begin
        n_err++;
        $display("FAIL fault_clear edge=%0d got=%b want=%b", k, fault[0], want);
      end
      n_vec++;
      if ({LED[0], fall_evt[0]} !== 2'b00) begin
        n_err++;
        $display("FAIL fault_quiet edge=%0d LED/fall=%b want=00", k, {LED[0], fall_evt[0]});
      end
    end
    button[0] = 1'b0;
    idle(DB + 6);
    n_vec++;
    if ({pad[0], LED[0], fall_evt[0], status[0]} !== 4'b1000) begin
      n_err++;
      $display("FAIL release0 pad/LED/fall/status=%b want=1000", {pad[0], LED[0], fall_evt[0], status[0]});
    end
  endtask

  // A 10-cycle press is rejected; a later long press needs the full count.
  task automatic test_glitch();
    button[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) button[1] = 1'b0;
      cyc();
      n_vec++;
      if (pad[1] !== 1'b1) begin
        n_err++;
        $display("FAIL glitch_pad1 cycle=%0d got=%b want=1", k, pad[1]);
      end
    end
    button[1] = 1'b1;
    for (int k = 1; k <= DB + 2; k++) begin
      logic want;
      cyc();
      want = (k >= DB + 2) ? 1'b0 : 1'b1;
      n_vec++;
      if (pad[1] !== want) begin
        n_err++;
        $display("FAIL glitch_restart edge=%0d got=%b want=%b", k, pad[1], want);
      end
    end
    button[1] = 1'b0;
    idle(DB + 6);
  endtask

  // External agent pulls channel 2 low while we are not driving it.
  task automatic test_ext_fall();
    ext_low[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] want;
      cyc();
      want = {(k >= 3), (k == 3), (k >= 3)};
      n_vec++;
      if ({LED[2], fall_evt[2], status[2]} !== want) begin
        n_err++;
        $display("FAIL ext_fall edge=%0d LED/fall/status=%b want=%b", k, {LED[2], fall_evt[2], status[2]}, want);
      end
    end
    ext_low[2] = 1'b0;
    idle(4);
    n_vec++;
    if ({LED[2], status[2]} !== 2'b01) begin
      n_err++;
      $display("FAIL ext_sticky LED/status=%b want=01", {LED[2], status[2]});
    end
    clr[2] = 1'b1;
    cyc();
    clr[2] = 1'b0;
    n_vec++;
    if (status[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ext_clr got=%b want=0", status[2]);
    end
    // New event with a clear landing on the very edge that sets the flag.
    ext_low[2] = 1'b1;
    idle(2);
    clr[2] = 1'b1;
    cyc();
    clr[2] = 1'b0;
    n_vec++;
    if ({fall_evt[2], status[2]} !== 2'b11) begin
      n_err++;
      $display("FAIL ext_set_wins fall/status=%b want=11", {fall_evt[2], status[2]});
    end
    cyc();
    n_vec++;
    if ({fall_evt[2], status[2]} !== 2'b01) begin
      n_err++;
      $display("FAIL ext_after_set fall/status=%b want=01", {fall_evt[2], status[2]});
    end
    ext_low[2] = 1'b0;
    idle(4);
  endtask

  // Channel 3 releases while the wire is held low a little longer.
  task automatic test_blank_release();
    bit seen;
    button[3] = 1'b1;
    idle(DB + 6);
    ext_low[3] = 1'b1;
    idle(4);
    button[3] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < DB + 10; k++) begin
      cyc();
      if (!m_db[3]) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL blank_timeout en3 never dropped within %0d cycles", DB + 10);
    end
    // Now just past the edge where drive ended.
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] want;
      cyc();
      if (k == 1) ext_low[3] = 1'b0;
      want = {(k == 3), (k == 3)};
      n_vec++;
      if ({LED[3], fall_evt[3]} !== want) begin
        n_err++;
        $display("FAIL blank_release edge=+%0d LED/fall=%b want=%b", k, {LED[3], fall_evt[3]}, want);
      end
    end
    clr[3] = 1'b1;
    cyc();
    clr[3] = 1'b0;
    idle(2);
  endtask

  // Reset hits while every channel is driving.
  task automatic test_reset_mid_drive();
    button = '1;
    idle(DB + 6);
    n_vec++;
    if (pad !== '0) begin
      n_err++;
      $display("FAIL all_drive pads got=%b want=0000", pad);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (pad !== '1) begin
      n_err++;
      $display("FAIL mid_rst_pads got=%b want=1111", pad);
    end
    n_vec++;
    if ({LED, fall_evt, status, fault} !== '0) begin
      n_err++;
      $display("FAIL mid_rst_outputs got=%h want=0", {LED, fall_evt, status, fault});
    end
    idle(2);
    rst = 1'b0;
    for (int k = 1; k <= DB + 3; k++) begin
      logic [N-1:0] want;
      cyc();
      want = (k >= DB + 2) ? '0 : '1;
      n_vec++;
      if (pad !== want) begin
        n_err++;
        $display("FAIL post_rst_pads edge=%0d got=%b want=%b", k, pad, want);
      end
      n_vec++;
      if ((LED | fall_evt) !== '0) begin
        n_err++;
        $display("FAIL post_rst_quiet edge=%0d LED=%b fall=%b want=0", k, LED, fall_evt);
      end
    end
    button = '0;
    idle(DB + 6);
  endtask

  // Randomized traffic on all channels compared against the model.
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 24) == 0) button[i]   = ~button[i];
        if ($urandom_range(0, 19) == 0) ext_low[i]  = ~ext_low[i];
        if ($urandom_range(0, 79) == 0) force_hi[i] = ~force_hi[i];
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      cyc();
      n_vec++;
      if (LED !== m_led) begin
        n_err++;
        $display("FAIL rand_LED cycle=%0d got=%b want=%b", c, LED, m_led);
      end
      n_vec++;
      if (fall_evt !== m_fall) begin
        n_err++;
        $display("FAIL rand_fall cycle=%0d got=%b want=%b", c, fall_evt, m_fall);
      end
      n_vec++;
      if (status !== m_stat) begin
        n_err++;
        $display("FAIL rand_status cycle=%0d got=%b want=%b", c, status, m_stat);
      end
      n_vec++;
      if (fault !== m_fault) begin
        n_err++;
        $display("FAIL rand_fault cycle=%0d got=%b want=%b", c, fault, m_fault);
      end
      n_vec++;
      if (pad !== pads_exp()) begin
        n_err++;
        $display("FAIL rand_pad cycle=%0d got=%b want=%b", c, pad, pads_exp());
      end
    end
    button = '0; ext_low = '0; force_hi = '0; clr = '0;
    idle(DB + 6);
  endtask

  initial begin
    test_reset();
    test_drive();
    test_fault();
    test_glitch();
    test_ext_fall();
    test_blank_release();
    test_reset_mid_drive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_od_gpio_bank
